data_mem_responder: RTL and testbench

//  Data-memory slave for the MEM stage: sinks the EX/MEM register's mem_read/mem_write

---
 rtl/data_mem_responder.sv | 92 +++++++++
 tb/tb_data_mem_responder.sv | 132 +++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency MEM-stage data RAM with byte/half/word lanes and busywait stall; DMEM_MISALIGN_CHECK_EN enables alignment checking
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mem_read,
  input  logic [2:0]  mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        busywait,
  output logic [31:0] read_data,
  output logic        misalign_err
);
  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [3:0] cnt;
  logic is_ld, is_st, mis, commit;
  logic [2:0] l_f3;
  logic [1:0] s_f3;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [31:0] a_data, word, ld_val, wdata;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  logic [3:0] be;
  logic [31:0] ram [DEPTH];
  wire req = mem_read[3] | mem_write[2];
  wire [ADDR_WIDTH-3:0] widx = a_addr[ADDR_WIDTH-1:2];
  assign busywait = (state == IDLE) ? req : (state == ACCESS);
`ifdef DMEM_MISALIGN_CHECK_EN
  assign mis = (is_ld && ((l_f3[1:0] == 2'b01 && a_addr[0]) || (l_f3 == 3'b010 && a_addr[1:0] != 2'b00)))
            || (is_st && ((s_f3 == 2'b01 && a_addr[0]) || (s_f3 == 2'b10 && a_addr[1:0] != 2'b00)));
`else
  assign mis = 1'b0;
`endif
  assign commit = rst && state == ACCESS && cnt == 4'd1 && is_st;
  always_comb begin
    word = ram[widx];
    byte_v = word[{a_addr[1:0], 3'b000} +: 8];
    half_v = a_addr[1] ? word[31:16] : word[15:0];
    ld_val = mis ? 32'd0 :
             l_f3 == 3'b000 ? {{24{byte_v[7]}}, byte_v} :
             l_f3 == 3'b001 ? {{16{half_v[15]}}, half_v} :
             l_f3 == 3'b010 ? word :
             l_f3 == 3'b100 ? {24'd0, byte_v} :
             l_f3 == 3'b101 ? {16'd0, half_v} : 32'd0;
    be = mis ? 4'b0000 :
         s_f3 == 2'b00 ? 4'b0001 << a_addr[1:0] :
         s_f3 == 2'b01 ? (a_addr[1] ? 4'b1100 : 4'b0011) :
         s_f3 == 2'b10 ? 4'b1111 : 4'b0000;
    wdata = s_f3 == 2'b00 ? {4{a_data[7:0]}} :
            s_f3 == 2'b01 ? {2{a_data[15:0]}} : a_data;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      read_data <= 32'd0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      if (state == IDLE && req) begin
        state <= ACCESS;
        cnt <= 4'(LATENCY);
        is_st <= mem_write[2];
        is_ld <= mem_read[3] & ~mem_write[2];
        l_f3 <= mem_read[2:0];
        s_f3 <= mem_write[1:0];
        a_addr <= address[ADDR_WIDTH-1:0];
        a_data <= write_data;
      end else if (state == ACCESS) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          state <= DONE;
          misalign_err <= mis;
          if (is_ld) read_data <= ld_val;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (commit)
      for (int i = 0; i < 4; i++)
        if (be[i]) ram[widx][8*i +: 8] <= wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for data_mem_responder
module tb_data_mem_responder;
  localparam int LAT = 2;
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] mem_read = 4'd0;
  logic [2:0] mem_write = 3'd0;
  logic [31:0] address = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic busywait, misalign_err;
  logic [31:0] read_data;
  typedef struct {
    string nm;
    logic chk;
    logic [31:0] rd;
    logic err;
  } exp_t;
  exp_t q[$];
  int pass_n = 0;
  int total_n = 0;
  always #5 clk = ~clk;
  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .address(address),
    .write_data(write_data),
    .busywait(busywait),
    .read_data(read_data),
    .misalign_err(misalign_err)
  );
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask
  task automatic issue(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                       input logic [31:0] data, input string nm, input logic chk,
                       input logic [31:0] exp_rd, input logic exp_err);
    bit ok = 1'b0;
    q.push_back('{nm, chk, exp_rd, exp_err});
    @(posedge clk); #1;
    mem_read = rd;
    mem_write = wr;
    address = addr;
    write_data = data;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!busywait) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({nm, "_timeout"}, {31'd0, busywait}, 32'd0);
  endtask
  task automatic idle();
    mem_read = 4'd0;
    mem_write = 3'd0;
    @(posedge clk); #1;
  endtask
  initial begin
    logic bw_p = 1'b0;
    logic rst_p = 1'b0;
    int len = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (bw_p && !busywait && rst_p) begin
        if (q.size() == 0) check("unexpected_response", 32'(q.size()), 32'd1);
        else begin
          e = q.pop_front();
          check({e.nm, "_busy"}, 32'(len), 32'(LAT + 1));
          if (e.chk) check({e.nm, "_data"}, read_data, e.rd);
          check({e.nm, "_err"}, {31'd0, misalign_err}, {31'd0, e.err});
        end
      end else if (misalign_err !== 1'b0) check("err_spurious", {31'd0, misalign_err}, 32'd0);
      if (busywait) len = bw_p ? len + 1 : 1;
      bw_p = busywait;
      rst_p = rst;
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busywait}, 32'd0);
    check("reset_rd", read_data, 32'd0);
    check("reset_err", {31'd0, misalign_err}, 32'd0);
    rst = 1'b1;
    issue(4'b0000, 3'b110, 32'h10, 32'hDEADBEEF, "sw10", 1'b0, 32'd0, 1'b0); idle();
    issue(4'b1010, 3'b000, 32'h10, 32'd0, "lw10", 1'b1, 32'hDEADBEEF, 1'b0); idle();
    issue(4'b1010, 3'b000, 32'h410, 32'd0, "lw_alias", 1'b1, 32'hDEADBEEF, 1'b0); idle();
    issue(4'b0000, 3'b110, 32'h20, 32'h11223344, "sw20", 1'b0, 32'd0, 1'b0); idle();
    issue(4'b0000, 3'b100, 32'h21, 32'hFFFFFF80, "sb21", 1'b0, 32'd0, 1'b0); idle();
    issue(4'b1000, 3'b000, 32'h21, 32'd0, "lb21", 1'b1, 32'hFFFFFF80, 1'b0); idle();
    issue(4'b1100, 3'b000, 32'h21, 32'd0, "lbu21", 1'b1, 32'h00000080, 1'b0); idle();
    issue(4'b1010, 3'b000, 32'h20, 32'd0, "lw20", 1'b1, 32'h11228044, 1'b0); idle();
    issue(4'b0000, 3'b110, 32'h30, 32'h00000000, "sw30", 1'b0, 32'd0, 1'b0); idle();
    issue(4'b0000, 3'b101, 32'h32, 32'hAAAA8001, "sh32", 1'b0, 32'd0, 1'b0); idle();
    issue(4'b1001, 3'b000, 32'h32, 32'd0, "lh32", 1'b1, 32'hFFFF8001, 1'b0); idle();
    issue(4'b1101, 3'b000, 32'h32, 32'd0, "lhu32", 1'b1, 32'h00008001, 1'b0); idle();
    issue(4'b1010, 3'b000, 32'h30, 32'd0, "lw30", 1'b1, 32'h80010000, 1'b0); idle();
    issue(4'b1010, 3'b110, 32'h50, 32'hCAFEF00D, "both50", 1'b1, 32'h80010000, 1'b0); idle();
    issue(4'b1010, 3'b000, 32'h50, 32'd0, "lw50", 1'b1, 32'hCAFEF00D, 1'b0); idle();
    issue(4'b1011, 3'b000, 32'h10, 32'd0, "lres", 1'b1, 32'd0, 1'b0); idle();
    issue(4'b1010, 3'b000, 32'h10, 32'd0, "b2b_a", 1'b1, 32'hDEADBEEF, 1'b0);
    issue(4'b1010, 3'b000, 32'h10, 32'd0, "b2b_b", 1'b1, 32'hDEADBEEF, 1'b0); idle();
    issue(4'b0000, 3'b110, 32'h40, 32'h0BADF00D, "sw40", 1'b0, 32'd0, 1'b0); idle();
    @(posedge clk); #1;
    mem_write = 3'b110;
    address = 32'h40;
    write_data = 32'h12345678;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_write = 3'b000;
    @(posedge clk); #1;
    check("midrst_busy", {31'd0, busywait}, 32'd0);
    check("midrst_rd", read_data, 32'd0);
    rst = 1'b1;
    issue(4'b1010, 3'b000, 32'h40, 32'd0, "lw40_old", 1'b1, 32'h0BADF00D, 1'b0); idle();
    issue(4'b1010, 3'b000, 32'h41, 32'd0, "lw41", 1'b1, MIS ? 32'd0 : 32'h0BADF00D, MIS); idle();
    repeat (3) idle();
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
